pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//   Parametrised program-counter sequencer for the multi-cycle RISC-V core.
//   Holds the fetch address, advances it by STEP once every CPI cycles and
//   accepts stall, jump, call/return and trap redirects. A return-address
//   stack (RAS) of RAS_DEPTH entries serves call/ret. Drives the instruction
//   memory address and the fetch strobe for the decode stage.
// PARAMETERS
//   XLEN       32     PC width in bits
//   CPI        4      cycles per instruction (>=1); phase counter modulus
//   STEP       1      sequential increment; power of two (1 = word-indexed IMEM)
//   RESET_VEC  0      PC value after reset
//   TRAP_VEC   'h10   PC value loaded on trap_en
//   RAS_DEPTH  4      return-address stack entries (power of two, >=2)
// PORTS
//   clk          in   1     clock, rising edge
//   rst          in   1     synchronous, active-high reset
//   stall        in   1     freeze pc and phase
//   jump_en      in   1     redirect to jump_target
//   jump_target  in   XLEN  redirect address
//   call         in   1     qualifies jump_en: push return address
//   ret_en       in   1     redirect to popped RAS top
//   trap_en      in   1     redirect to TRAP_VEC
//   pc           out  XLEN  current fetch address
//   phase        out  PW    PW = max(1,$clog2(CPI)); cycle within instruction
//   fetch_strobe out  1     high while phase==0 and !stall
//   ras_empty    out  1     RAS holds no entries
//   ras_full     out  1     RAS holds RAS_DEPTH entries
//   ras_err      out  1     one-cycle pulse: overflow push or underflow pop
//   misalign     out  1     one-cycle pulse: jump_target not STEP-aligned
// BEHAVIOUR
//   - Reset: pc=RESET_VEC, phase=0, RAS emptied (ras_empty=1, ras_full=0),
//     ras_err=0, misalign=0. Reset overrides every other input.
//   - Priority per cycle: rst > trap_en > jump_en > ret_en > stall > sequential.
//   - Sequential: phase increments each cycle; when phase==CPI-1, next cycle
//     pc<=pc+STEP (mod 2^XLEN, wraps silently) and phase<=0. CPI=1: pc
//     advances every unstalled cycle, phase constant 0.
//   - stall: pc and phase hold; RAS unchanged. Redirects override stall.
//   - Any redirect (trap/jump/ret): takes effect next cycle, phase<=0, so a
//     fresh instruction starts and fetch_strobe is high that cycle.
//   - jump_en: pc<=jump_target with low log2(STEP) bits forced to 0; if those
//     bits were nonzero, misalign pulses next cycle.
//   - jump_en && call: push pc+STEP onto RAS. If full, oldest entry is
//     overwritten (circular), ras_full stays 1, ras_err pulses.
//   - ret_en (no jump_en/trap_en): if RAS non-empty, pc<=top, pop. If empty,
//     pc<=pc+STEP (fall-through), ras_err pulses.
//   - jump_en && ret_en: jump wins, no pop. call without jump_en: ignored.
//   - trap_en: pc<=TRAP_VEC, RAS cleared, no push/pop that cycle.
//   - Outputs pc/phase/flags are registered; fetch_strobe is combinational
//     from phase and stall only.
// TESTING
//   1. rst 1 cycle, CPI=4, STEP=1 -> pc=0 for 4 cycles, then 1,2,...;
//      fetch_strobe high every 4th cycle, phase 0,1,2,3,0.
//   2. stall high 3 cycles at phase=2, pc=5 -> pc=5, phase=2 held; resumes
//      phase 3 then pc=6.
//   3. pc=7, jump_en+call, target=0x40 -> pc=0x40, phase=0; later ret_en ->
//      pc=8, ras_empty=1.
//   4. 5 nested calls (RAS_DEPTH=4) -> ras_err pulse on 5th; 4 rets return
//      newest four addresses; 5th ret -> ras_err, pc=pc+1.
//   5. trap_en with jump_en and stall at phase=1 -> pc=0x10, phase=0, RAS empty.
//   6. STEP=4, XLEN=8: jump_target=0x13 -> pc=0x10, misalign pulse; pc=0xFC
//      sequential -> wraps to 0x00.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: phase counter, stall, jump/call/ret/trap redirects
// and a circular return-address stack.
module pc_sequencer #(
  parameter int unsigned      XLEN      = 32,
  parameter int unsigned      CPI       = 4,
  parameter int unsigned      STEP      = 1,
  parameter logic [XLEN-1:0]  RESET_VEC = '0,
  parameter logic [XLEN-1:0]  TRAP_VEC  = 'h10,
  parameter int unsigned      RAS_DEPTH = 4,
  localparam int unsigned     PW        = (CPI > 1) ? $clog2(CPI) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_target,
  input  logic            call,
  input  logic            ret_en,
  input  logic            trap_en,
  output logic [XLEN-1:0] pc,
  output logic [PW-1:0]   phase,
  output logic            fetch_strobe,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_err,
  output logic            misalign
);

  localparam int unsigned     SH         = (STEP > 1) ? $clog2(STEP) : 0;
  localparam int unsigned     AW         = $clog2(RAS_DEPTH);
  localparam logic [XLEN-1:0] STEP_V     = XLEN'(STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << SH) - XLEN'(1));
  localparam logic [PW-1:0]   LAST_PH    = PW'(CPI - 1);
  localparam logic [AW:0]     FULL_CNT   = RAS_DEPTH[AW:0];

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [AW-1:0]   top;
  logic [AW:0]     cnt;
  logic [XLEN-1:0] pc_seq;

  assign pc_seq       = pc + STEP_V;
  assign fetch_strobe = (phase == '0) && !stall;
  assign ras_empty    = (cnt == '0);
  assign ras_full     = (cnt == FULL_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_VEC;
      phase    <= '0;
      top      <= '0;
      cnt      <= '0;
      ras_err  <= 1'b0;
      misalign <= 1'b0;
    end else begin
      ras_err  <= 1'b0;
      misalign <= 1'b0;
      if (trap_en) begin
        pc    <= TRAP_VEC;
        phase <= '0;
        top   <= '0;
        cnt   <= '0;
      end else if (jump_en) begin
        pc       <= jump_target & ALIGN_MASK;
        phase    <= '0;
        misalign <= |(jump_target & ~ALIGN_MASK);
        if (call) begin
          // Pushing past full lands on the oldest slot, so the ring overwrites it.
          ras_mem[top + AW'(1)] <= pc_seq;
          top                   <= top + AW'(1);
          if (cnt == FULL_CNT) ras_err <= 1'b1;
          else                 cnt     <= cnt + 1'b1;
        end
      end else if (ret_en) begin
        phase <= '0;
        if (cnt != '0) begin
          pc  <= ras_mem[top];
          top <= top - AW'(1);
          cnt <= cnt - 1'b1;
        end else begin
          pc      <= pc_seq;
          ras_err <= 1'b1;
        end
      end else if (!stall) begin
        if (phase == LAST_PH) begin
          phase <= '0;
          pc    <= pc_seq;
        end else begin
          phase <= phase + PW'(1);
        end
      end
    end
  end

endmodule
